// File: rtl/conv_pkg.sv
// Shared types for the convolution datapath: pixel, kernel boundary flags,
// position counters and the tagged beat handed to the window builder.
package conv_pkg;

    localparam int PIXEL_W           = 8;
    localparam int IMAGE_MAX_W       = 1920;
    localparam int IMAGE_H           = 6;
    localparam int KERNEL_DIAMETER_N = 5;

    localparam int CW = $clog2(IMAGE_MAX_W);
    localparam int RW = $clog2(IMAGE_H);

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef struct packed {
        logic n2;
        logic n1;
        logic s2;
        logic s1;
        logic w2;
        logic w1;
        logic e2;
        logic e1;
    } kernel_pos_t;

    localparam int KERNEL_POS_W = $bits(kernel_pos_t);

    typedef logic [CW:0]   col_t;
    typedef logic [RW-1:0] row_t;

    typedef struct packed {
        pixel_t      data;
        kernel_pos_t pos;
        logic        sof;
        logic        eol;
        logic        eof;
    } pos_beat_t;

    // Narrower lines than the kernel would make the edge flags overlap.
    function automatic col_t clamp_width(input col_t w);
        if (w < col_t'(KERNEL_DIAMETER_N))
            return col_t'(KERNEL_DIAMETER_N);
        if (w > col_t'(IMAGE_MAX_W))
            return col_t'(IMAGE_MAX_W);
        return w;
    endfunction

endpackage

// File: rtl/conv_skid_buf.sv
// Generic 2-entry valid/ready skid buffer; s_ready is registered and
// means "skid entry empty", so m_ready never reaches s_ready combinationally.
module conv_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
);

    logic         r_ready;
    logic         r_m_valid;
    logic         r_s_valid;
    logic [W-1:0] r_m_data;
    logic [W-1:0] r_s_data;
    logic         w_push;
    logic         w_pop;

    assign w_push = s_valid && r_ready;
    assign w_pop  = r_m_valid && m_ready;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_ready   <= 1'b0;
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
            r_m_data  <= '0;
            r_s_data  <= '0;
        end else if (r_s_valid) begin
            if (w_pop) begin
                r_m_data  <= r_s_data;
                r_s_valid <= 1'b0;
                r_ready   <= 1'b1;
            end
        end else begin
            r_ready <= 1'b1;
            if (w_push) begin
                // Reload main in the same cycle it drains: no bubble.
                if (!r_m_valid || w_pop) begin
                    r_m_data  <= s_data;
                    r_m_valid <= 1'b1;
                end else begin
                    r_s_data  <= s_data;
                    r_s_valid <= 1'b1;
                    r_ready   <= 1'b0;
                end
            end else if (w_pop) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign s_ready = r_ready;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;

endmodule

// File: rtl/conv_pos_tagger.sv
// Tracks raster (x, y) of each accepted pixel and tags it with kernel
// boundary flags and sof/eol/eof for the window builder.
module conv_pos_tagger
    import conv_pkg::*;
(
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic [CW:0]             cfg_width,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [PIXEL_W-1:0]      s_data,
    input  logic                    s_sof,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [PIXEL_W-1:0]      m_data,
    output logic [KERNEL_POS_W-1:0] m_pos,
    output logic                    m_sof,
    output logic                    m_eol,
    output logic                    m_eof,
    output logic                    err_sync
);

    localparam col_t C_ONE    = col_t'(1);
    localparam col_t C_TWO    = col_t'(2);
    localparam row_t R_ONE    = row_t'(1);
    localparam row_t R_LAST   = row_t'(IMAGE_H - 1);
    localparam row_t R_PENULT = row_t'(IMAGE_H - 2);

    col_t        r_x;
    col_t        r_w;
    row_t        r_y;
    logic        r_err;
    col_t        w_x;
    col_t        w_width;
    row_t        w_y;
    logic        w_accept;
    logic        w_origin;
    logic        w_last_col;
    logic        w_last_row;
    logic        w_sync_err;
    pos_beat_t   w_in_beat;
    pos_beat_t   w_out_beat;

    assign w_accept   = s_valid && s_ready;
    assign w_origin   = (r_x == '0) && (r_y == '0);
    // A sof beat is always treated as (0,0), resynchronising the counters.
    assign w_x        = s_sof ? '0 : r_x;
    assign w_y        = s_sof ? '0 : r_y;
    assign w_width    = (s_sof || w_origin) ? clamp_width(cfg_width) : r_w;
    assign w_last_col = (w_x == w_width - C_ONE);
    assign w_last_row = (w_y == R_LAST);
    assign w_sync_err = s_sof ? !w_origin : w_origin;

    always_comb begin
        w_in_beat        = '0;
        w_in_beat.data   = s_data;
        w_in_beat.pos.w1 = (w_x == '0);
        w_in_beat.pos.w2 = (w_x <= C_ONE);
        w_in_beat.pos.e1 = w_last_col;
        w_in_beat.pos.e2 = (w_x >= w_width - C_TWO);
        w_in_beat.pos.n1 = (w_y == '0);
        w_in_beat.pos.n2 = (w_y <= R_ONE);
        w_in_beat.pos.s1 = w_last_row;
        w_in_beat.pos.s2 = (w_y >= R_PENULT);
        w_in_beat.sof    = (w_x == '0) && (w_y == '0);
        w_in_beat.eol    = w_last_col;
        w_in_beat.eof    = w_last_col && w_last_row;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_x   <= '0;
            r_y   <= '0;
            r_w   <= col_t'(IMAGE_MAX_W);
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && w_sync_err;
            if (w_accept) begin
                r_w <= w_width;
                if (w_last_col) begin
                    r_x <= '0;
                    r_y <= w_last_row ? '0 : w_y + R_ONE;
                end else begin
                    r_x <= w_x + C_ONE;
                    r_y <= w_y;
                end
            end
        end
    end

    conv_skid_buf #(
        .W($bits(pos_beat_t))
    ) u_skid (
        .clk     (clk),
        .arst_n  (arst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (w_in_beat),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (w_out_beat)
    );

    assign m_data   = w_out_beat.data;
    assign m_pos    = w_out_beat.pos;
    assign m_sof    = w_out_beat.sof;
    assign m_eol    = w_out_beat.eol;
    assign m_eof    = w_out_beat.eof;
    assign err_sync = r_err;

endmodule

// File: tb/tb_conv_pos_tagger.sv
// Bench for conv_pos_tagger: frame-index model plus directed vectors
// covering flags, backpressure, clamping, resync and mid-frame reset.
module tb_conv_pos_tagger;
    import conv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [CW:0] cfg_width = 8;
    logic        s_valid = 1'b0;
    logic        s_ready;
    pixel_t      s_data = '0;
    logic        s_sof = 1'b0;
    logic        m_valid;
    logic        m_ready;
    pixel_t      m_data;
    kernel_pos_t m_pos;
    logic        m_sof;
    logic        m_eol;
    logic        m_eof;
    logic        err_sync;

    always #5 clk = ~clk;

    conv_pos_tagger dut (
        .clk       (clk),
        .arst_n    (rst_n),
        .cfg_width (cfg_width),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_sof     (s_sof),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_pos     (m_pos),
        .m_sof     (m_sof),
        .m_eol     (m_eol),
        .m_eof     (m_eof),
        .err_sync  (err_sync)
    );

    int        checks = 0;
    int        errors = 0;
    pos_beat_t exp_q[$];
    pos_beat_t obs[$];
    int        mk = 0;
    int        mw = IMAGE_MAX_W;
    int        occ = 0;
    int        since_rst = 0;
    int        stalls = 0;
    int        rdy_mode = 0;
    logic      exp_err = 1'b0;
    logic      stall_prev = 1'b0;
    pos_beat_t prev_beat = '0;
    pixel_t    d_cnt = '0;

    function automatic int clampw(input int w);
        if (w < KERNEL_DIAMETER_N) return KERNEL_DIAMETER_N;
        if (w > IMAGE_MAX_W) return IMAGE_MAX_W;
        return w;
    endfunction

    // Model: beat index k within the frame; position is (k % W, k / W).
    task automatic model_accept(input pixel_t d, input logic sof, input int cfg);
        int k, x, y;
        pos_beat_t b;
        exp_err = sof ? (mk != 0) : (mk == 0);
        k = sof ? 0 : mk;
        if (k == 0) mw = clampw(cfg);
        x = k % mw;
        y = k / mw;
        b = '0;
        b.data   = d;
        b.pos.w1 = (x == 0);
        b.pos.w2 = (x < 2);
        b.pos.e1 = (x == mw - 1);
        b.pos.e2 = (x > mw - 3);
        b.pos.n1 = (y == 0);
        b.pos.n2 = (y < 2);
        b.pos.s1 = (y == IMAGE_H - 1);
        b.pos.s2 = (y > IMAGE_H - 3);
        b.sof    = (k == 0);
        b.eol    = (x == mw - 1);
        b.eof    = (k == mw * IMAGE_H - 1);
        exp_q.push_back(b);
        mk = (k + 1) % (mw * IMAGE_H);
    endtask

    always @(posedge clk) begin : mon
        logic acc, pop;
        if (rst_n) begin
            acc = s_valid && s_ready;
            pop = m_valid && m_ready;
            if (acc) model_accept(s_data, s_sof, int'(cfg_width));
            else exp_err = 1'b0;
            occ = occ + int'(acc) - int'(pop);
        end
    end

    always @(negedge clk) begin : cmp
        pos_beat_t cur, e;
        logic want;
        if (rst_n) begin
            cur = '0;
            cur.data = m_data;
            cur.pos  = m_pos;
            cur.sof  = m_sof;
            cur.eol  = m_eol;
            cur.eof  = m_eof;
            checks++;
            if (err_sync !== exp_err) begin
                errors++;
                $display("FAIL err_sync got %b want %b t=%0t", err_sync, exp_err, $time);
            end
            if (since_rst > 0) begin
                want = (occ < 2);
                checks++;
                if (s_ready !== want) begin
                    errors++;
                    $display("FAIL s_ready got %b want %b t=%0t", s_ready, want, $time);
                end
            end
            since_rst++;
            want = (occ > 0);
            checks++;
            if (m_valid !== want) begin
                errors++;
                $display("FAIL m_valid got %b want %b t=%0t", m_valid, want, $time);
            end
            if (stall_prev) begin
                checks++;
                if (cur !== prev_beat) begin
                    errors++;
                    $display("FAIL hold got %h want %h t=%0t", cur, prev_beat, $time);
                end
            end
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat got %h want none t=%0t", cur, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        errors++;
                        $display("FAIL beat got %h want %h t=%0t", cur, e, $time);
                    end
                end
                obs.push_back(cur);
            end
            stall_prev = m_valid && !m_ready;
            prev_beat  = cur;
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: m_ready = 1'b1;
                1: m_ready = ($urandom_range(0, 99) < 30);
                default: m_ready = 1'b0;
            endcase
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic send(input logic sof);
        int n;
        logic ok;
        s_valid = 1'b1;
        s_sof   = sof;
        s_data  = d_cnt;
        d_cnt++;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 1000) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            n++;
        end
        #1;
        if (n > 1) stalls++;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got no accept want accept");
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic send_n(input int n, input logic first_sof);
        for (int i = 0; i < n; i++) send(first_sof && i == 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() > 0 || m_valid) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d left want 0", exp_q.size());
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        occ        = 0;
        mk         = 0;
        exp_err    = 1'b0;
        stall_prev = 1'b0;
        since_rst  = 0;
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_m_data", int'(m_data), 0);
        chk("rst_m_pos", int'(m_pos), 0);
        chk("rst_flags", int'({m_sof, m_eol, m_eof}), 0);
        chk("rst_err", int'(err_sync), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : stim
        int b;
        apply_reset();
        @(posedge clk);
        #1;
        chk("s_ready_after_rst", int'(s_ready), 1);

        // Small frame W=8, no stalls
        cfg_width = 8;
        b = obs.size();
        stalls = 0;
        send(1'b1);
        chk("t1_latency", int'(m_valid), 1);
        send_n(47, 1'b0);
        drain();
        chk("t1_stalls", stalls, 0);
        chk("t1_b0_pos", int'(obs[b].pos), 'hCC);
        chk("t1_b0_sof", int'(obs[b].sof), 1);
        chk("t1_b7_pos", int'(obs[b+7].pos), 'hC3);
        chk("t1_b7_eol", int'(obs[b+7].eol), 1);
        chk("t1_b46_pos", int'(obs[b+46].pos), 'h32);
        chk("t1_b47_eof", int'(obs[b+47].eof), 1);

        // Backpressure over two frames
        rdy_mode = 1;
        b = obs.size();
        send_n(48, 1'b1);
        send_n(48, 1'b1);
        drain();
        rdy_mode = 0;
        chk("t2_count", obs.size() - b, 96);

        // Width clamp, low and high
        cfg_width = 2;
        b = obs.size();
        send_n(30, 1'b1);
        drain();
        chk("clamp_lo_b3_pos", int'(obs[b+3].pos), 'hC2);
        chk("clamp_lo_b4_pos", int'(obs[b+4].pos), 'hC3);
        chk("clamp_lo_b4_eol", int'(obs[b+4].eol), 1);
        cfg_width = 4000;
        b = obs.size();
        send_n(1920, 1'b1);
        drain();
        chk("clamp_hi_b1918_eol", int'(obs[b+1918].eol), 0);
        chk("clamp_hi_b1918_pos", int'(obs[b+1918].pos), 'hC2);
        chk("clamp_hi_b1919_eol", int'(obs[b+1919].eol), 1);

        // Resync on beat 13; then finish that frame
        cfg_width = 8;
        b = obs.size();
        send_n(13, 1'b1);
        send(1'b1);
        chk("resync_err", int'(err_sync), 1);
        send_n(47, 1'b0);
        drain();
        chk("resync_b13_pos", int'(obs[b+13].pos), 'hCC);
        chk("resync_b13_sof", int'(obs[b+13].sof), 1);
        chk("resync_b14_pos", int'(obs[b+14].pos), 'hC8);
        chk("resync_b15_pos", int'(obs[b+15].pos), 'hC0);

        // Width change mid-frame, then missing sof
        cfg_width = 5;
        b = obs.size();
        send_n(10, 1'b1);
        cfg_width = 8;
        send_n(20, 1'b0);
        send(1'b0);
        chk("nosof_err", int'(err_sync), 1);
        send_n(7, 1'b0);
        drain();
        chk("wchg_b14_eol", int'(obs[b+14].eol), 1);
        chk("wchg_b34_eol", int'(obs[b+34].eol), 0);
        chk("wchg_b37_eol", int'(obs[b+37].eol), 1);

        // Reset with beats pending
        rdy_mode = 2;
        @(posedge clk);
        #2;
        send_n(2, 1'b1);
        apply_reset();
        rdy_mode = 0;
        @(posedge clk);
        #1;
        b = obs.size();
        send(1'b1);
        drain();
        chk("post_rst_sof", int'(obs[b].sof), 1);
        chk("post_rst_pos", int'(obs[b].pos), 'hCC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
